shift_inc_unit: RTL and testbench

Parametrised successor to the team's 4-bit load/double/increment register. Holds a WIDTH-bit result register that can be:
- loaded directly from the input,
- shifted left or right, or rotated left, by a programmable amount,
- optionally incremented after the shift.

Serial variant shifts one bit per clock under a start/busy/done handshake. Sits in the parity_counter_and_shifter datapath and feeds parity and overflow status to downstream counters.

---
 rtl/shift_inc_pkg.sv | 31 +++
 rtl/shift_inc_step.sv | 46 ++++
 rtl/shift_inc_unit.sv | 175 +++++++++++++++++
 tb/tb_shift_inc_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_inc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_inc_pkg
// Brief    : Opcodes, FSM state encoding and helpers shared by shift_inc_unit.
// Revision : 1.0 - initial release
// ============================================================================
package shift_inc_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_LOAD     = 3'b000;
    localparam op_t OP_LOAD_INC = 3'b001;
    localparam op_t OP_SHL      = 3'b010;
    localparam op_t OP_SHL_INC  = 3'b011;
    localparam op_t OP_SHR      = 3'b100;
    localparam op_t OP_ROL      = 3'b101;
    localparam op_t OP_INC      = 3'b110;
    localparam op_t OP_NOP      = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_INC   = 2'd2
    } state_t;

    function automatic logic is_shift_op(input op_t op);
        return (op == OP_SHL) || (op == OP_SHL_INC) || (op == OP_SHR) || (op == OP_ROL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_inc_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_inc_step
// Brief    : Combinational shift/rotate/increment by a given amount, with
//            carry-out (OR of bits shifted out of the MSB, or increment wrap).
// Revision : 1.0 - initial release
// ============================================================================
module shift_inc_step #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] amount,
    output logic [WIDTH-1:0]   result,
    output logic               carry
);
    import shift_inc_pkg::*;

    // Zero-extended left shift keeps the bits that fall off the MSB in the upper half.
    logic [2*WIDTH-1:0] w_shl_wide;
    logic [WIDTH-1:0]   w_rol;

    assign w_shl_wide = {{WIDTH{1'b0}}, operand} << amount;
    assign w_rol      = (operand << amount) | (operand >> (WIDTH - int'(amount)));

    always_comb begin
        result = operand;
        carry  = 1'b0;
        case (op)
            OP_SHL, OP_SHL_INC: begin
                result = w_shl_wide[WIDTH-1:0];
                carry  = |w_shl_wide[2*WIDTH-1:WIDTH];
            end
            OP_SHR: result = operand >> amount;
            OP_ROL: result = w_rol;
            OP_LOAD_INC, OP_INC: begin
                result = operand + WIDTH'(1);
                carry  = &operand;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_inc_unit.sv
`default_nettype none
// ============================================================================
// Module   : shift_inc_unit
// Brief    : Load / shift / rotate / increment result register with a
//            start-busy-done handshake, overflow and parity status.
//            Define SHIFT_INC_BARREL_EN for single-cycle barrel shifting.
// Revision : 1.0 - initial release
// ============================================================================
module shift_inc_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               parity
);
    import shift_inc_pkg::*;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    op_t                r_op;
    logic [SHAMT_W-1:0] r_count;
    logic               r_done;
    logic               r_ovf;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_data_nxt;
    op_t                w_op_nxt;
    logic [SHAMT_W-1:0] w_count_nxt;
    logic               w_done_nxt;
    logic               w_ovf_nxt;

    op_t                w_step_op;
    logic [WIDTH-1:0]   w_step_in;
    logic [SHAMT_W-1:0] w_step_amt;
    logic [WIDTH-1:0]   w_step_res;
    logic               w_step_carry;

    // Single datapath step shared by IDLE increments, serial shifts and the INC state.
    always_comb begin
        w_step_op  = OP_NOP;
        w_step_in  = r_data;
        w_step_amt = SHAMT_W'(1);
        case (r_state)
            S_IDLE: begin
`ifdef SHIFT_INC_BARREL_EN
                if (is_shift_op(op)) begin
                    w_step_op  = op;
                    w_step_in  = data_in;
                    w_step_amt = shamt;
                end else begin
                    w_step_op  = OP_INC;
                end
`else
                w_step_op = OP_INC;
`endif
            end
            S_SHIFT: w_step_op = r_op;
            S_INC:   w_step_op = OP_INC;
            default: ;
        endcase
    end

    shift_inc_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .op      (w_step_op),
        .operand (w_step_in),
        .amount  (w_step_amt),
        .result  (w_step_res),
        .carry   (w_step_carry)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_op_nxt    = r_op;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_op_nxt  = op;
                    w_ovf_nxt = 1'b0;
                    case (op)
                        OP_LOAD: begin
                            w_data_nxt = data_in;
                            w_done_nxt = 1'b1;
                        end
                        OP_NOP: w_done_nxt = 1'b1;
                        OP_INC: begin
                            w_data_nxt = w_step_res;
                            w_ovf_nxt  = w_step_carry;
                            w_done_nxt = 1'b1;
                        end
                        OP_LOAD_INC: begin
                            w_data_nxt  = data_in;
                            w_state_nxt = S_INC;
                        end
                        default: begin
`ifdef SHIFT_INC_BARREL_EN
                            w_data_nxt = w_step_res;
                            w_ovf_nxt  = w_step_carry;
                            if (op == OP_SHL_INC) w_state_nxt = S_INC;
                            else                  w_done_nxt  = 1'b1;
`else
                            w_data_nxt  = data_in;
                            w_count_nxt = shamt;
                            if (shamt != '0)           w_state_nxt = S_SHIFT;
                            else if (op == OP_SHL_INC) w_state_nxt = S_INC;
                            else                       w_done_nxt  = 1'b1;
`endif
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                w_data_nxt  = w_step_res;
                w_ovf_nxt   = r_ovf | w_step_carry;
                w_count_nxt = r_count - SHAMT_W'(1);
                if (r_count == SHAMT_W'(1)) begin
                    if (r_op == OP_SHL_INC) begin
                        w_state_nxt = S_INC;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_INC: begin
                w_data_nxt  = w_step_res;
                w_ovf_nxt   = r_ovf | w_step_carry;
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_op    <= OP_NOP;
            r_count <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_op    <= w_op_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign data_out = r_data;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign overflow = r_ovf;
    assign parity   = ^r_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_inc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_inc_unit
// Brief    : Directed and random checks of shift_inc_unit against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_inc_unit;

    localparam int WIDTH   = 8;
    localparam int SHAMT_W = 3;
    localparam int MAX_CYC = 64;
`ifdef SHIFT_INC_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    localparam logic [2:0] C_LOAD = 3'd0, C_LOAD_INC = 3'd1, C_SHL = 3'd2, C_SHL_INC = 3'd3;
    localparam logic [2:0] C_SHR  = 3'd4, C_ROL = 3'd5, C_INC = 3'd6, C_NOP = 3'd7;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               start   = 1'b0;
    logic [2:0]         op      = '0;
    logic [SHAMT_W-1:0] shamt   = '0;
    logic [WIDTH-1:0]   data_in = '0;
    logic [WIDTH-1:0]   data_out;
    logic               busy;
    logic               done;
    logic               overflow;
    logic               parity;

    int               tests   = 0;
    int               fails   = 0;
    logic [WIDTH-1:0] model_q = '0;

    shift_inc_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .shamt    (shamt),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .parity   (parity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, result} computed with plain integer arithmetic.
    function automatic logic [WIDTH:0] ref_op(input logic [2:0] o, input logic [WIDTH-1:0] d,
                                              input int s, input logic [WIDTH-1:0] cur);
        longint m, x, v;
        logic   ov;
        m  = longint'(1) << WIDTH;
        x  = longint'(d);
        ov = 1'b0;
        case (o)
            C_LOAD: v = x;
            C_LOAD_INC: begin
                v  = (x + 1) % m;
                ov = (x == m - 1);
            end
            C_SHL, C_SHL_INC: begin
                v  = x * (longint'(1) << s);
                ov = (v >= m);
                v  = v % m;
                if (o == C_SHL_INC) begin
                    ov = ov | (v == m - 1);
                    v  = (v + 1) % m;
                end
            end
            C_SHR: v = x / (longint'(1) << s);
            C_ROL: v = ((x * (longint'(1) << s)) % m) + (x / (longint'(1) << (WIDTH - s)));
            C_INC: begin
                v  = (longint'(cur) + 1) % m;
                ov = (longint'(cur) == m - 1);
            end
            default: v = longint'(cur);
        endcase
        return {ov, v[WIDTH-1:0]};
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input int s);
        case (o)
            C_LOAD_INC:          return 2;
            C_SHL, C_SHR, C_ROL: return BARREL ? 1 : 1 + s;
            C_SHL_INC:           return BARREL ? 2 : 2 + s;
            default:             return 1;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] d, input int s);
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = SHAMT_W'(s);
        @(negedge clk);
        start   = 1'b0;
        op      = 3'($urandom);
        data_in = WIDTH'($urandom);
        shamt   = SHAMT_W'($urandom);
    endtask

    task automatic await_done(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] d,
                              input int s, input int cyc0);
        logic [WIDTH:0] r;
        int             cyc;
        r   = ref_op(o, d, s, model_q);
        cyc = cyc0;
        while (done !== 1'b1 && cyc < MAX_CYC) begin
            check({tag, "/busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            cyc++;
        end
        check({tag, "/done"},     32'(done),     32'd1);
        check({tag, "/latency"},  32'(cyc),      32'(ref_latency(o, s)));
        check({tag, "/busy_end"}, 32'(busy),     32'd0);
        check({tag, "/data"},     32'(data_out), 32'(r[WIDTH-1:0]));
        check({tag, "/ovf"},      32'(overflow), 32'(r[WIDTH]));
        check({tag, "/parity"},   32'(parity),   32'($countones(r[WIDTH-1:0]) % 2));
        model_q = r[WIDTH-1:0];
    endtask

    initial begin
        logic           saw_done;
        logic [2:0]     ro;
        logic [WIDTH-1:0] rd;
        int             rs;

        repeat (2) @(negedge clk);
        check("reset/data",   32'(data_out), 32'd0);
        check("reset/busy",   32'(busy),     32'd0);
        check("reset/done",   32'(done),     32'd0);
        check("reset/ovf",    32'(overflow), 32'd0);
        check("reset/parity", 32'(parity),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(C_LOAD_INC, 8'hFF, 0); await_done("load_inc_ff", C_LOAD_INC, 8'hFF, 0, 1);
        check("load_inc_ff/const", 32'({overflow, data_out}), 32'h100);
        issue(C_SHL, 8'h81, 3);      await_done("shl_81_3", C_SHL, 8'h81, 3, 1);
        check("shl_81_3/const", 32'({overflow, parity, data_out}), 32'h308);
        issue(C_ROL, 8'h81, 1);      await_done("rol_81_1", C_ROL, 8'h81, 1, 1);
        check("rol_81_1/const", 32'(data_out), 32'h03);
        issue(C_SHL_INC, 8'h01, 2);  await_done("shlinc_01_2", C_SHL_INC, 8'h01, 2, 1);
        check("shlinc_01_2/const", 32'(data_out), 32'h05);
        issue(C_SHR, 8'h80, 7);      await_done("shr_80_7", C_SHR, 8'h80, 7, 1);
        check("shr_80_7/const", 32'({overflow, data_out}), 32'h001);
        issue(C_SHL_INC, 8'hFF, 0);  await_done("shlinc_ff_0", C_SHL_INC, 8'hFF, 0, 1);

        // A start while busy must not disturb the running operation.
        issue(C_SHL_INC, 8'h81, 3);
        start = 1'b1; op = C_LOAD; data_in = 8'h55;
        @(negedge clk);
        start = 1'b0;
        await_done("ignore_busy", C_SHL_INC, 8'h81, 3, 2);
        issue(C_LOAD, 8'h55, 0);     await_done("start_in_done", C_LOAD, 8'h55, 0, 1);
        check("start_in_done/const", 32'(data_out), 32'h55);

        // Reset during an operation aborts it without a done pulse.
        @(negedge clk);
        issue(C_SHL_INC, 8'hFF, 5);
        check("abort/busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort/data", 32'(data_out), 32'd0);
        check("abort/busy", 32'(busy),     32'd0);
        check("abort/ovf",  32'(overflow), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort/no_done", 32'(saw_done), 32'd0);
        model_q = '0;

        issue(C_LOAD, 8'h05, 0); await_done("load_05", C_LOAD, 8'h05, 0, 1);
        repeat (3) begin
            issue(C_INC, 8'hA5, 0); await_done("inc", C_INC, 8'hA5, 0, 1);
        end
        check("inc3/const", 32'({overflow, parity, data_out}), 32'h108);
        issue(C_NOP, 8'h3C, 5);  await_done("nop", C_NOP, 8'h3C, 5, 1);
        @(negedge clk);
        check("nop/done_width", 32'(done), 32'd0);
        check("nop/hold", 32'(data_out), 32'h08);

        issue(C_LOAD, 8'hFF, 0); await_done("load_ff", C_LOAD, 8'hFF, 0, 1);
        issue(C_INC, 8'h00, 0);  await_done("inc_wrap", C_INC, 8'h00, 0, 1);

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rd = WIDTH'($urandom);
            rs = $urandom_range(0, (1 << SHAMT_W) - 1);
            issue(ro, rd, rs);
            await_done("random", ro, rd, rs, 1);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
